// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory access stage: FSM state encoding and
// default bus widths.
package mem_stage_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int PREG_W = 5;
  localparam int ARCH_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/memstage_fwd_reg.sv
// One-entry store-forwarding register. Holds the address and data of the
// most recently completed store. Provides a combinational exact-address
// compare for a load that is being accepted.
module memstage_fwd_reg
  import mem_stage_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] laddr,
  output logic          hit,
  output logic [DW-1:0] rdata
);

  logic          valid;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;

  // Capture each completed store; a store to the same address simply overwrites.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (we) begin
      valid <= 1'b1;
      addr  <= waddr;
      data  <= wdata;
    end
  end

  assign hit   = valid & (addr == laddr);
  assign rdata = data;

endmodule

// File: rtl/memory_access_stage.sv
// Memory access stage of the load/store path. Accepts one resolved memory
// operation at a time, issues a single outstanding request to the data
// memory, and returns the result on the writeback handshake.
// Optional feature: define STORE_FWD_EN to add a one-entry store-forwarding
// register so a load hitting the last store address skips memory.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no operation in flight, ready for input
//   REQ   | memory request presented, waiting for mem_req_ready
//   WAIT  | load request accepted, waiting for mem_rdata_valid
//   DONE  | writeback beat presented, waiting for wb_ready
module memory_access_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = mem_stage_pkg::ADDR_W,
  parameter int DATA_W = mem_stage_pkg::DATA_W,
  parameter int PREG_W = mem_stage_pkg::PREG_W,
  parameter int ARCH_W = mem_stage_pkg::ARCH_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [PREG_W-1:0] in_dest_reg,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ARCH_W-1:0] in_dest_arch_regs,
  input  logic              in_store,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdata_valid,
  output logic [PREG_W-1:0] wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic [ARCH_W-1:0] wb_arch_regs,
  output logic              wb_store,
  output logic              wb_valid,
  input  logic              wb_ready
);

  state_e state, state_next;

  logic              accept;
  logic              fwd_hit;
  logic              fwd_load;
  logic              store_done;
  logic [DATA_W-1:0] fwd_data;
  logic [PREG_W-1:0] tag_q;
  logic [ARCH_W-1:0] arch_q;
  logic              store_q;

  assign in_ready   = (state == IDLE) | ((state == DONE) & wb_ready);
  assign accept     = in_valid & in_ready;
  assign fwd_load   = accept & ~in_store & fwd_hit;
  assign store_done = (state == REQ) & mem_req_ready & store_q;

`ifdef STORE_FWD_EN
  memstage_fwd_reg #(
    .AW(ADDR_W),
    .DW(DATA_W)
  ) u_fwd (
    .clk   (clk),
    .rst   (rst),
    .we    (store_done),
    .waddr (mem_addr),
    .wdata (mem_wdata),
    .laddr (in_addr),
    .hit   (fwd_hit),
    .rdata (fwd_data)
  );
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; a newly accepted op goes to REQ, or straight to DONE on a forward hit.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = fwd_load ? DONE : REQ;
      REQ:  if (mem_req_ready) state_next = store_q ? DONE : WAIT;
      WAIT: if (mem_rdata_valid) state_next = DONE;
      DONE: begin
        if (wb_ready) begin
          if (accept) state_next = fwd_load ? DONE : REQ;
          else        state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered memory-side and writeback-side outputs plus latched op fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_we        <= 1'b0;
      mem_req_valid <= 1'b0;
      wb_reg        <= '0;
      wb_data       <= '0;
      wb_arch_regs  <= '0;
      wb_store      <= 1'b0;
      wb_valid      <= 1'b0;
      tag_q         <= '0;
      arch_q        <= '0;
      store_q       <= 1'b0;
    end else if (accept) begin
      mem_addr      <= in_addr;
      mem_wdata     <= in_data;
      mem_we        <= in_store;
      tag_q         <= in_dest_reg;
      arch_q        <= in_dest_arch_regs;
      store_q       <= in_store;
      mem_req_valid <= ~fwd_load;
      wb_valid      <= fwd_load;
      if (fwd_load) begin
        wb_reg       <= in_dest_reg;
        wb_data      <= fwd_data;
        wb_arch_regs <= in_dest_arch_regs;
        wb_store     <= 1'b0;
      end
    end else begin
      case (state)
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            if (store_q) begin
              // Stores carry no register result: tag and data are zero.
              wb_valid     <= 1'b1;
              wb_store     <= 1'b1;
              wb_data      <= '0;
              wb_reg       <= '0;
              wb_arch_regs <= arch_q;
            end
          end
        end
        WAIT: begin
          if (mem_rdata_valid) begin
            wb_valid     <= 1'b1;
            wb_store     <= 1'b0;
            wb_data      <= mem_rdata;
            wb_reg       <= tag_q;
            wb_arch_regs <= arch_q;
          end
        end
        DONE: if (wb_ready) wb_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed self-checking bench for memory_access_stage.
module tb_memory_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_addr;
  logic [4:0]  in_dest_reg;
  logic [7:0]  in_data;
  logic [7:0]  in_dest_arch_regs;
  logic        in_store;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [7:0]  mem_rdata;
  logic        mem_rdata_valid;
  logic [4:0]  wb_reg;
  logic [7:0]  wb_data;
  logic [7:0]  wb_arch_regs;
  logic        wb_store;
  logic        wb_valid;
  logic        wb_ready;

  int n_chk = 0;
  int n_bad = 0;

  memory_access_stage dut (
    .clk               (clk),
    .rst               (rst),
    .in_addr           (in_addr),
    .in_dest_reg       (in_dest_reg),
    .in_data           (in_data),
    .in_dest_arch_regs (in_dest_arch_regs),
    .in_store          (in_store),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_we            (mem_we),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .mem_rdata         (mem_rdata),
    .mem_rdata_valid   (mem_rdata_valid),
    .wb_reg            (wb_reg),
    .wb_data           (wb_data),
    .wb_arch_regs      (wb_arch_regs),
    .wb_store          (wb_store),
    .wb_valid          (wb_valid),
    .wb_ready          (wb_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_op(input logic st, input logic [15:0] a, input logic [7:0] d,
                        input logic [4:0] tg, input logic [7:0] ar);
    in_valid          = 1'b1;
    in_store          = st;
    in_addr           = a;
    in_data           = d;
    in_dest_reg       = tg;
    in_dest_arch_regs = ar;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_store = 1'b0; in_addr = '0; in_data = '0;
    in_dest_reg = '0; in_dest_arch_regs = '0;
    mem_req_ready = 1'b1; mem_rdata = '0; mem_rdata_valid = 1'b0;
    wb_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_in_ready", in_ready, 1);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_store", wb_store, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_wb_data", wb_data, 0);

    // Reset while a load to 0x0200 waits; late response must be dropped
    put_op(1'b0, 16'h0200, 8'h00, 5'd3, 8'h01);
    tick();
    in_valid = 1'b0;
    chk("w_req_valid", mem_req_valid, 1);
    chk("w_req_addr", mem_addr, 16'h0200);
    tick();
    chk("w_in_wait", mem_req_valid, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_rdata = 8'hAA; mem_rdata_valid = 1'b1;
    tick();
    mem_rdata_valid = 1'b0;
    chk("w_drop_wb_valid", wb_valid, 0);
    chk("w_drop_in_ready", in_ready, 1);
    tick();
    chk("w_drop_wb_valid2", wb_valid, 0);

    // Store 0x5A to 0x1234
    put_op(1'b1, 16'h1234, 8'h5A, 5'd2, 8'h81);
    tick();
    in_valid = 1'b0;
    chk("st_req_valid", mem_req_valid, 1);
    chk("st_we", mem_we, 1);
    chk("st_addr", mem_addr, 16'h1234);
    chk("st_wdata", mem_wdata, 8'h5A);
    chk("st_wb_early", wb_valid, 0);
    tick();
    chk("st_wb_valid", wb_valid, 1);
    chk("st_wb_store", wb_store, 1);
    chk("st_wb_data", wb_data, 0);
    chk("st_wb_arch", wb_arch_regs, 8'h81);
    chk("st_req_drop", mem_req_valid, 0);
    tick();
    chk("st_wb_done", wb_valid, 0);

    // Load 0x00FF tag 7, response three cycles after the request is taken
    put_op(1'b0, 16'h00FF, 8'h00, 5'd7, 8'h10);
    tick();
    in_valid = 1'b0;
    chk("ld_req_valid", mem_req_valid, 1);
    chk("ld_we", mem_we, 0);
    tick();
    tick();
    chk("ld_wait_wb", wb_valid, 0);
    tick();
    mem_rdata = 8'h3C; mem_rdata_valid = 1'b1;
    tick();
    mem_rdata_valid = 1'b0;
    chk("ld_wb_valid", wb_valid, 1);
    chk("ld_wb_reg", wb_reg, 7);
    chk("ld_wb_data", wb_data, 8'h3C);
    chk("ld_wb_store", wb_store, 0);
    chk("ld_wb_arch", wb_arch_regs, 8'h10);
    tick();
    chk("ld_one_beat", wb_valid, 0);

    // mem_req_ready held low for 5 cycles
    mem_req_ready = 1'b0;
    put_op(1'b0, 16'h0456, 8'h00, 5'd9, 8'h02);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_valid", mem_req_valid, 1);
      chk("bp_addr", mem_addr, 16'h0456);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_wb_valid", wb_valid, 0);
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    chk("bp_released", mem_req_valid, 0);
    mem_rdata = 8'h11; mem_rdata_valid = 1'b1;
    tick();
    mem_rdata_valid = 1'b0;
    chk("bp_wb_valid_end", wb_valid, 1);
    chk("bp_wb_data", wb_data, 8'h11);
    chk("bp_wb_reg", wb_reg, 9);
    tick();

    // wb_ready held low for 4 cycles with a new op waiting
    wb_ready = 1'b0;
    put_op(1'b1, 16'h0500, 8'h21, 5'd1, 8'h44);
    tick();
    put_op(1'b0, 16'h0600, 8'h00, 5'd4, 8'h08);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("wbp_wb_valid", wb_valid, 1);
      chk("wbp_wb_store", wb_store, 1);
      chk("wbp_wb_arch", wb_arch_regs, 8'h44);
      chk("wbp_in_ready", in_ready, 0);
      chk("wbp_no_req", mem_req_valid, 0);
      tick();
    end
    wb_ready = 1'b1;
    #1;
    chk("wbp_in_ready_rel", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("wbp_next_req", mem_req_valid, 1);
    chk("wbp_next_addr", mem_addr, 16'h0600);
    chk("wbp_wb_cleared", wb_valid, 0);
    tick();
    mem_rdata = 8'h5C; mem_rdata_valid = 1'b1;
    tick();
    mem_rdata_valid = 1'b0;
    chk("wbp_ld_data", wb_data, 8'h5C);
    chk("wbp_ld_reg", wb_reg, 4);
    tick();

    // Store 0x77 to 0x0300, then load 0x0300
    put_op(1'b1, 16'h0300, 8'h77, 5'd0, 8'h00);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    put_op(1'b0, 16'h0300, 8'h00, 5'd6, 8'h20);
    tick();
    in_valid = 1'b0;
`ifdef STORE_FWD_EN
    chk("fw_wb_valid", wb_valid, 1);
    chk("fw_wb_data", wb_data, 8'h77);
    chk("fw_wb_reg", wb_reg, 6);
    chk("fw_no_req", mem_req_valid, 0);
    tick();
    chk("fw_no_req2", mem_req_valid, 0);
    chk("fw_beat_end", wb_valid, 0);
    // Overwrite the entry with 0x88 and forward again
    put_op(1'b1, 16'h0300, 8'h88, 5'd0, 8'h00);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    put_op(1'b0, 16'h0300, 8'h00, 5'd5, 8'h00);
    tick();
    in_valid = 1'b0;
    chk("fw2_wb_valid", wb_valid, 1);
    chk("fw2_wb_data", wb_data, 8'h88);
    chk("fw2_no_req", mem_req_valid, 0);
    tick();
`else
    chk("nf_req_valid", mem_req_valid, 1);
    chk("nf_wb_valid", wb_valid, 0);
    tick();
    mem_rdata = 8'h99; mem_rdata_valid = 1'b1;
    tick();
    mem_rdata_valid = 1'b0;
    chk("nf_wb_data", wb_data, 8'h99);
    tick();
`endif

    // Load from 0x0301 must go to memory
    put_op(1'b0, 16'h0301, 8'h00, 5'd1, 8'h00);
    tick();
    in_valid = 1'b0;
    chk("miss_req_valid", mem_req_valid, 1);
    chk("miss_addr", mem_addr, 16'h0301);
    chk("miss_wb_valid", wb_valid, 0);
    tick();
    mem_rdata = 8'h42; mem_rdata_valid = 1'b1;
    tick();
    mem_rdata_valid = 1'b0;
    chk("miss_wb_data", wb_data, 8'h42);
    chk("miss_wb_reg", wb_reg, 1);
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
